hazard_controller: RTL
======================

Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS datapath.
- Detects load-use and branch-operand hazards and stalls the front end.
- Flushes IF/ID on taken branches, which are resolved in ID by the equality comparator.
- Freezes the front end while a multi-cycle EX operation runs, and generates registered forwarding selects for the two EX-stage 3:1 operand muxes.

Parameters:
- RW, 5, register address width.
- MC_CYCLES, 4, EX occupancy in cycles of a multi-cycle op (legal range 2..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- id_rs  input  RW  rs field of the instruction in ID.
- id_rt  input  RW  rt field of the instruction in ID.
- id_branch  input  1  instruction in ID is beq/bne.
- branch_taken  input  1  branch condition true (from ID comparator).
- id_multi  input  1  instruction in ID is a multi-cycle EX op.
- ex_rd  input  RW  destination register of the instruction in EX.
- ex_reg_write  input  1  EX instruction writes the register file.
- ex_mem_read  input  1  EX instruction is a load.
- mem_rd  input  RW  destination register of the instruction in MEM.
- mem_reg_write  input  1  MEM instruction writes the register file.
- mem_mem_read  input  1  MEM instruction is a load.
- pc_write  output  1  PC register enable.
- ifid_write  output  1  IF/ID register enable.
- ifid_flush  output  1  clear IF/ID to nop.
- idex_write  output  1  ID/EX register enable.
- idex_bubble  output  1  load nop control into ID/EX.
- exmem_bubble  output  1  load nop control into EX/MEM.
- fwd_a  output  2  EX operand A mux select.
- fwd_b  output  2  EX operand B mux select.
- mc_busy  output  1  multi-cycle op occupying EX.

Behaviour:
- FSM states: RUN, MC_BUSY. 4-bit down-counter cnt.
- Reset (async, while rst=1): state=RUN, cnt=0, fwd_a=fwd_b=00. Outputs while rst=1: pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1, ifid_flush=0, exmem_bubble=0, mc_busy=0.
- Match rule: a register r matches a source when r!=0 and r equals id_rs or id_rt. Register 0 never matches.
- lu_haz = ex_mem_read & ex_rd matches.
- br_haz = id_branch & ((ex_reg_write & ex_rd matches) | (mem_mem_read & mem_rd matches)).
- stall = lu_haz | br_haz. Evaluated combinationally, same cycle.
- RUN, stall=1: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0. branch_taken is ignored.
- RUN, stall=0: pc_write=1, ifid_write=1, idex_write=1, idex_bubble=0. ifid_flush=id_branch&branch_taken.
- RUN, stall=0, id_multi=1: next state MC_BUSY, cnt=MC_CYCLES-1.
- MC_BUSY: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1, mc_busy=1, ifid_flush=0. All hazard inputs are ignored.
- MC_BUSY counting: cnt decrements each cycle. At cnt==1 the next state is RUN and cnt=0. The op therefore holds EX for exactly MC_CYCLES cycles, the last being a RUN cycle with exmem_bubble=0.
- fwd_a/fwd_b are registered and computed in ID for the instruction entering EX next cycle, per source operand independently:
  - 10 if ex_reg_write & ex_rd==src & src!=0 (producer reaches MEM next cycle).
  - else 01 if mem_reg_write & mem_rd==src & src!=0.
  - else 00.
  - EX priority over MEM.
- fwd update rules: idex_bubble=1 loads 00 into both; idex_write=0 holds both.
- Simultaneous events:
  - Stall and taken branch: stall wins, no flush.
  - Stall and id_multi: stall first, multi accepted on the first non-stall cycle.
  - rst asserted mid-MC_BUSY: immediate return to RUN with reset outputs.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds output stall_cycles[15:0], reset to 0. It increments by 1 every cycle pc_write=0 and rst=0, and saturates at 16'hFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8 -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle. Next cycle (load in MEM, ex_mem_read=0) -> fwd_a=01 registered, no stall.
- Forward priority: ex_reg_write=1, ex_rd=5, mem_reg_write=1, mem_rd=5, id_rt=5 -> fwd_b=10 after edge. Same with rd=0 -> fwd_b=00.
- Taken branch: id_branch=1, branch_taken=1, no hazards -> ifid_flush=1 for one cycle. Then with ex_reg_write=1, ex_rd=id_rs=3 -> stall, ifid_flush=0.
- Multi-cycle (MC_CYCLES=4): id_multi=1 in RUN -> mc_busy=1 and exmem_bubble=1 for 3 cycles, then RUN, pc_write=1. Assert lu_haz during busy -> no effect.
- Async reset: assert rst mid-MC_BUSY between edges -> mc_busy=0, fwd_a=fwd_b=00, idex_bubble=1 immediately. Release -> RUN, pc_write=1.
- HAZARD_PERF_CNT_EN: 1 load-use stall plus a 4-cycle multi op -> stall_cycles=4. Forced 70000 stall cycles -> stall_cycles=16'hFFFF.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage MIPS datapath.
// Stalls the front end on load-use and branch-operand hazards, flushes IF/ID on taken
// branches resolved in ID, freezes the front end while a multi-cycle EX op runs, and
// produces registered forwarding selects for the two EX operand muxes.
// Optional: define HAZARD_PERF_CNT_EN to add the saturating stall_cycles counter.
module hazard_controller #(
  parameter int unsigned RW        = 5,
  parameter int unsigned MC_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_branch,
  input  logic          branch_taken,
  input  logic          id_multi,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] mem_rd,
  input  logic          mem_reg_write,
  input  logic          mem_mem_read,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          ifid_flush,
  output logic          idex_write,
  output logic          idex_bubble,
  output logic          exmem_bubble,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          mc_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]   stall_cycles
`endif
);

  typedef enum logic [0:0] {StRun, StMcBusy} state_e;

  // Counter load value: the issuing RUN cycle is not counted, the final RUN cycle is.
  localparam logic [3:0] McInit = 4'(MC_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] fwd_a_q, fwd_b_q;
  logic [1:0] fwd_a_d, fwd_b_d;
  logic       lu_haz, br_haz, stall;

  // Register 0 is hardwired to zero, so it never creates a dependency.
  function automatic logic src_match(input logic [RW-1:0] r,
                                     input logic [RW-1:0] a,
                                     input logic [RW-1:0] b);
    return (r != '0) && ((r == a) || (r == b));
  endfunction

  // EX producer is younger than MEM producer, so it takes priority.
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src,
                                         input logic          exw,
                                         input logic [RW-1:0] exrd,
                                         input logic          memw,
                                         input logic [RW-1:0] memrd);
    if (src == '0) begin
      return 2'b00;
    end else if (exw && (exrd == src)) begin
      return 2'b10;
    end else if (memw && (memrd == src)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  // Hazard detection, evaluated in the same cycle as the instruction sits in ID.
  always_comb begin
    lu_haz = ex_mem_read && src_match(ex_rd, id_rs, id_rt);
    br_haz = id_branch && ((ex_reg_write && src_match(ex_rd, id_rs, id_rt)) ||
                           (mem_mem_read && src_match(mem_rd, id_rs, id_rt)));
    stall  = lu_haz || br_haz;
    fwd_a_d = fwd_sel(id_rs, ex_reg_write, ex_rd, mem_reg_write, mem_rd);
    fwd_b_d = fwd_sel(id_rt, ex_reg_write, ex_rd, mem_reg_write, mem_rd);
  end

  // Next-state and pipeline control outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    mc_busy      = 1'b0;
    if (rst) begin
      idex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (stall) begin
            // Stall wins over a taken branch and defers a multi-cycle op.
            idex_bubble = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = id_branch && branch_taken;
            if (id_multi) begin
              state_d = StMcBusy;
              cnt_d   = McInit;
            end
          end
        end
        StMcBusy: begin
          idex_write   = 1'b0;
          exmem_bubble = 1'b1;
          mc_busy      = 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = StRun;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      endcase
    end
  end

  // State and occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Forwarding selects travel with the instruction into ID/EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else if (idex_bubble) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else if (idex_write) begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles_q;

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 16'd0;
    end else if (!pc_write && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_q <= stall_cycles_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
